// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus bundle between the core's bridge master and the SRAM slave.
// Side-band fields (lock/cache/prot, wid) travel with the bus but the slave ignores them.
interface axi_sram_slave_if;
  // read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Byte-writable SRAM endpoint for AXI3-style bursts. One read and one write
// may be outstanding at a time; the two channels run independently.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   R_IDLE  | arready high, waiting for a read address
//   R_BURST | presenting read beats, one per rready handshake
//   W_IDLE  | awready high, waiting for a write address
//   W_DATA  | wready high, writing each accepted beat into the array
//   W_RESP  | bvalid high, holding bid/bresp until bready
module axi_sram_slave #(
  parameter int MEM_WORDS_LOG2 = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_sram_slave_if.slave  bus
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  typedef enum logic {R_IDLE, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [DEPTH];

  // FIXED keeps the address; INCR steps by the transfer size with 32-bit wrap.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst,
                                            input logic [2:0]  size);
    if (burst == 2'b01) return addr + (32'd1 << size);
    return addr;
  endfunction

  // WRAP and reserved bursts, and transfers wider than the 32-bit bus, are refused.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size > 3'd2);
  endfunction

  // ---------------------------------------------------------------- read side
  rstate_t     rstate_q, rstate_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [7:0]  rbeat_q, rbeat_d;
  logic        rerr_q, rerr_d;

  logic [MEM_WORDS_LOG2-1:0] ridx;
  assign ridx = raddr_q[MEM_WORDS_LOG2+1:2];

  // Read state and burst context registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rbeat_q  <= rbeat_d;
      rerr_q   <= rerr_d;
    end
  end

  // Read next-state: capture on AR, step beat/address on each accepted beat.
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rbeat_d  = rbeat_q;
    rerr_d   = rerr_q;
    case (rstate_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          rid_d    = bus.arid;
          raddr_d  = bus.araddr;
          rlen_d   = bus.arlen;
          rsize_d  = bus.arsize;
          rburst_d = bus.arburst;
          rbeat_d  = '0;
          rerr_d   = burst_err(bus.arburst, bus.arsize);
          rstate_d = R_BURST;
        end
      end
      R_BURST: begin
        if (bus.rready) begin
          if (rbeat_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + 8'd1;
            raddr_d = next_addr(raddr_q, rburst_q, rsize_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Data-side outputs are forced to zero outside a burst so idle cycles are clean.
  assign bus.arready = (rstate_q == R_IDLE);
  assign bus.rvalid  = (rstate_q == R_BURST);
  assign bus.rid     = rid_q;
  assign bus.rlast   = (rstate_q == R_BURST) && (rbeat_q == rlen_q);
  assign bus.rresp   = ((rstate_q == R_BURST) && rerr_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rdata   = ((rstate_q == R_BURST) && !rerr_q) ? mem[ridx] : 32'd0;

  // --------------------------------------------------------------- write side
  wstate_t     wstate_q, wstate_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic        werr_q, werr_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [MEM_WORDS_LOG2-1:0] widx;
  logic                      mem_we;
  assign widx   = waddr_q[MEM_WORDS_LOG2+1:2];
  assign mem_we = (wstate_q == W_DATA) && bus.wvalid && !werr_q;

  // Write state and burst context registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q <= W_IDLE;
      bid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      bid_q    <= bid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      bresp_q  <= bresp_d;
    end
  end

  // Write next-state: the wlast beat decides bresp from burst type and beat count.
  always_comb begin
    wstate_d = wstate_q;
    bid_d    = bid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (bus.awvalid) begin
          bid_d    = bus.awid;
          waddr_d  = bus.awaddr;
          wlen_d   = bus.awlen;
          wsize_d  = bus.awsize;
          wburst_d = bus.awburst;
          wcnt_d   = '0;
          werr_d   = burst_err(bus.awburst, bus.awsize);
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid) begin
          // saturate so an overlong burst can never wrap back to a matching count
          if (wcnt_q != 9'h1FF) wcnt_d = wcnt_q + 9'd1;
          waddr_d = next_addr(waddr_q, wburst_q, wsize_q);
          if (bus.wlast) begin
            bresp_d  = (werr_q || (wcnt_q != {1'b0, wlen_q})) ? RESP_SLVERR : RESP_OKAY;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign bus.awready = (wstate_q == W_IDLE);
  assign bus.wready  = (wstate_q == W_DATA);
  assign bus.bvalid  = (wstate_q == W_RESP);
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;

  // Byte-lane array update; contents survive reset on purpose.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{bus.arlock, bus.arcache, bus.arprot,
                             bus.awlock, bus.awcache, bus.awprot, bus.wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam int LOG2  = 8;
  localparam int DEPTH = 1 << LOG2;
  localparam int LIMIT = 400;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi_sram_slave_if bus();
  axi_sram_slave #(.MEM_WORDS_LOG2(LOG2)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wdat [512];
  logic [3:0]  wstb [512];
  logic [31:0] rd_got [$];
  int          rd_cycles;

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Reference model: byte address of beat i, and the word it lands on.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [2:0] size, input int i);
    if (burst == 2'b00) return a;
    return a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[LOG2+1:2]);
  endfunction

  function automatic bit is_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst >= 2'd2) || (size > 3'd2);
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input bit rnd, input logic [1:0] exp_bresp);
    int n;
    logic [31:0] a;
    bit err;
    err = is_err(burst, size);
    @(negedge aclk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1) begin
      if (n >= LIMIT) begin timeout("awready"); bus.awvalid = 1'b0; return; end
      @(negedge aclk); n++;
    end
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("wready_after_aw", bus.wready, 1);
    chk("awready_busy", bus.awready, 0);
    for (int i = 0; i < nbeats; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge aclk);
      bus.wdata = wdat[i]; bus.wstrb = wstb[i]; bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1) begin
        if (n >= LIMIT) begin timeout("wready"); bus.wvalid = 1'b0; return; end
        @(negedge aclk); n++;
      end
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      if (!err) begin
        a = beat_addr(addr, burst, size, i);
        for (int b = 0; b < 4; b++)
          if (wstb[i][b]) ref_mem[widx(a)][8*b +: 8] = wdat[i][8*b +: 8];
      end
    end
    chk("bvalid_after_wlast", bus.bvalid, 1);
    if (rnd) begin
      repeat ($urandom_range(0, 3)) begin
        chk("bvalid_hold", bus.bvalid, 1);
        chk("bid_hold", bus.bid, id);
        chk("bresp_hold", bus.bresp, exp_bresp);
        @(negedge aclk);
      end
    end
    chk("bid", bus.bid, id);
    chk("bresp", bus.bresp, exp_bresp);
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    chk("bvalid_clear", bus.bvalid, 0);
    chk("awready_back", bus.awready, 1);
  endtask

  // mode 0: rready always high; 1: random; 2: per-cycle pattern pat[cyc]
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode,
                         input logic [15:0] pat, input int abort_beat);
    int n, i, cyc;
    bit err;
    logic rr;
    logic [31:0] exp;
    err = is_err(burst, size);
    rd_got.delete();
    @(negedge aclk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1) begin
      if (n >= LIMIT) begin timeout("arready"); bus.arvalid = 1'b0; return; end
      @(negedge aclk); n++;
    end
    @(negedge aclk);
    bus.arvalid = 1'b0;
    i = 0; cyc = 0;
    while (i <= int'(len)) begin
      if (cyc >= LIMIT) begin timeout("rbeats"); bus.rready = 1'b0; return; end
      exp = err ? 32'd0 : ref_mem[widx(beat_addr(addr, burst, size, i))];
      if (i == abort_beat) begin
        aresetn = 1'b0;
        #1;
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_arready", bus.arready, 1);
        chk("rst_awready", bus.awready, 1);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        bus.rready = 1'b0;
        rd_cycles = cyc;
        return;
      end
      chk("rvalid", bus.rvalid, 1);
      chk("rid", bus.rid, id);
      chk("rdata", bus.rdata, exp);
      chk("rlast", bus.rlast, 32'(i == int'(len)));
      chk("rresp", bus.rresp, err ? 32'd2 : 32'd0);
      chk("arready_busy", bus.arready, 0);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(0, 1));
        default: rr = (cyc < 16) ? pat[cyc] : 1'b1;
      endcase
      bus.rready = rr;
      if (rr) rd_got.push_back(bus.rdata);
      @(negedge aclk);
      cyc++;
      if (rr) i++;
    end
    bus.rready = 1'b0;
    rd_cycles = cyc;
    chk("rvalid_end", bus.rvalid, 0);
    chk("rdata_idle", bus.rdata, 0);
    chk("arready_end", bus.arready, 1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_rd, a_wr;
    logic [7:0]  len_r, len_w;
    logic [2:0]  sz;
    logic [1:0]  br;
    int          nb, sel;

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);

    chk("reset_arready", bus.arready, 1);
    chk("reset_awready", bus.awready, 1);
    chk("reset_rvalid", bus.rvalid, 0);
    chk("reset_rlast", bus.rlast, 0);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_rid", bus.rid, 0);
    chk("reset_rresp", bus.rresp, 0);
    chk("reset_wready", bus.wready, 0);
    chk("reset_bvalid", bus.bvalid, 0);
    chk("reset_bid", bus.bid, 0);
    chk("reset_bresp", bus.bresp, 0);
    aresetn = 1'b1;

    // W-before-AW: wready stays low while idle
    bus.wvalid = 1'b1; bus.wdata = 32'hDEAD0000; bus.wstrb = 4'hF;
    @(negedge aclk);
    chk("w_before_aw_wready", bus.wready, 0);
    bus.wvalid = 1'b0;

    // Preload the whole array so every read has a defined expectation.
    for (int i = 0; i < DEPTH; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(4'h0, 32'h0, 8'd255, 3'd2, 2'b01, DEPTH, 1'b0, 2'b00);

    // Write-then-read cache line
    for (int i = 0; i < 8; i++) begin wdat[i] = 32'h100 + 32'(i); wstb[i] = 4'hF; end
    do_write(4'h1, 32'h1C000040, 8'd7, 3'd2, 2'b01, 8, 1'b0, 2'b00);
    do_read(4'h3, 32'h1C000040, 8'd7, 3'd2, 2'b01, 0, 16'h0, -1);
    chk("line_cycles", 32'(rd_cycles), 8);
    chk("line_beats", 32'(rd_got.size()), 8);
    for (int i = 0; i < 8 && i < rd_got.size(); i++) chk("line_data", rd_got[i], 32'h100 + 32'(i));

    // Byte strobes
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    do_write(4'h2, 32'h1C000000, 8'd0, 3'd2, 2'b01, 1, 1'b0, 2'b00);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    do_write(4'h2, 32'h1C000000, 8'd0, 3'd2, 2'b01, 1, 1'b0, 2'b00);
    do_read(4'h4, 32'h1C000000, 8'd0, 3'd2, 2'b01, 0, 16'h0, -1);
    chk("strobe_data", (rd_got.size() > 0) ? rd_got[0] : 32'hXXXXXXXX, 32'h11BB33DD);

    // Backpressure with rready 1,0,0,1,1,0,1
    do_read(4'h5, 32'h1C000040, 8'd3, 3'd2, 2'b01, 2, 16'h0059, -1);
    chk("bp_cycles", 32'(rd_cycles), 7);
    for (int i = 0; i < 4 && i < rd_got.size(); i++) chk("bp_data", rd_got[i], 32'h100 + 32'(i));

    // Error read: WRAP burst
    do_read(4'h6, 32'h1C000040, 8'd1, 3'd2, 2'b10, 0, 16'h0, -1);
    chk("err_rd_beats", 32'(rd_got.size()), 2);
    for (int i = 0; i < rd_got.size(); i++) chk("err_rd_data", rd_got[i], 0);

    // Short write: len 3 but wlast on beat 1
    wdat[0] = 32'hE0; wdat[1] = 32'hE1; wstb[0] = 4'hF; wstb[1] = 4'hF;
    do_write(4'h7, 32'h200, 8'd3, 3'd2, 2'b01, 2, 1'b0, 2'b10);
    do_read(4'h8, 32'h200, 8'd3, 3'd2, 2'b01, 0, 16'h0, -1);
    if (rd_got.size() >= 2) begin
      chk("short_w0", rd_got[0], 32'hE0);
      chk("short_w1", rd_got[1], 32'hE1);
    end else timeout("short_read");

    // Table-driven vectors
    vecs[0]  = '{1'b1, 4'h2, 32'h00000080, 8'd3, 3'd2, 2'b01, 4, 4'hF, 2'b00};
    vecs[1]  = '{1'b0, 4'h4, 32'h00000080, 8'd3, 3'd2, 2'b01, 0, 4'h0, 2'b00};
    vecs[2]  = '{1'b1, 4'h5, 32'h00000090, 8'd2, 3'd2, 2'b00, 3, 4'h3, 2'b00};
    vecs[3]  = '{1'b0, 4'h6, 32'h00000090, 8'd2, 3'd2, 2'b00, 0, 4'h0, 2'b00};
    vecs[4]  = '{1'b1, 4'h7, 32'h000000A1, 8'd3, 3'd0, 2'b01, 4, 4'hA, 2'b00};
    vecs[5]  = '{1'b0, 4'h8, 32'h000000A0, 8'd3, 3'd1, 2'b01, 0, 4'h0, 2'b00};
    vecs[6]  = '{1'b1, 4'h9, 32'h000000B0, 8'd1, 3'd2, 2'b11, 2, 4'hF, 2'b10};
    vecs[7]  = '{1'b0, 4'hA, 32'h000000B0, 8'd0, 3'd2, 2'b11, 0, 4'h0, 2'b10};
    vecs[8]  = '{1'b0, 4'hB, 32'h000000B0, 8'd1, 3'd3, 2'b01, 0, 4'h0, 2'b10};
    vecs[9]  = '{1'b1, 4'hC, 32'h000000C0, 8'd1, 3'd2, 2'b01, 3, 4'hF, 2'b10};
    vecs[10] = '{1'b0, 4'hD, 32'hFFFFFCC0, 8'd2, 3'd2, 2'b01, 0, 4'h0, 2'b00};
    vecs[11] = '{1'b1, 4'hE, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 2, 4'hF, 2'b00};
    vecs[12] = '{1'b0, 4'hF, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 0, 4'h0, 2'b00};
    vecs[13] = '{1'b1, 4'h1, 32'h000001C0, 8'd3, 3'd2, 2'b10, 4, 4'hF, 2'b10};
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].is_wr) begin
        for (int i = 0; i < vecs[v].nbeats; i++) begin wdat[i] = $urandom; wstb[i] = vecs[v].strb; end
        do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                 vecs[v].nbeats, 1'b0, vecs[v].exp_resp);
      end else begin
        do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0, 16'h0, -1);
        chk("vec_rd_beats", 32'(rd_got.size()), 32'(vecs[v].len) + 1);
        for (int i = 0; i < rd_got.size(); i++)
          if (vecs[v].exp_resp != 2'b00) chk("vec_err_data", rd_got[i], 0);
      end
    end

    // Concurrent read and write to different lines
    for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    fork
      do_read(4'h9, 32'h1C000040, 8'd7, 3'd2, 2'b01, 1, 16'h0, -1);
      do_write(4'hA, 32'h300, 8'd7, 3'd2, 2'b01, 8, 1'b1, 2'b00);
    join
    do_read(4'hB, 32'h300, 8'd7, 3'd2, 2'b01, 0, 16'h0, -1);

    // Reset in the middle of a read, then a normal read
    do_read(4'h5, 32'h1C000040, 8'd7, 3'd2, 2'b01, 0, 16'h0, 2);
    do_read(4'h6, 32'h1C000040, 8'd7, 3'd2, 2'b01, 0, 16'h0, -1);
    chk("post_reset_cycles", 32'(rd_cycles), 8);
    for (int i = 0; i < 8 && i < rd_got.size(); i++) chk("post_reset_data", rd_got[i], 32'h100 + 32'(i));

    // Randomized concurrent traffic: reads in the low half, writes in the high half
    for (int t = 0; t < 40; t++) begin
      len_r = 8'($urandom_range(0, 15));
      len_w = 8'($urandom_range(0, 15));
      a_rd  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 100)) << 2) | 32'($urandom_range(0, 3));
      a_wr  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(128, 228)) << 2) | 32'($urandom_range(0, 3));
      sz    = 3'($urandom_range(0, 3));
      sel   = $urandom_range(0, 9);
      br    = (sel < 2) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
      nb    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, int'(len_w) + 2) : int'(len_w) + 1;
      for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      fork
        do_read(4'($urandom), a_rd, len_r, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1, 16'h0, -1);
        do_write(4'($urandom), a_wr, len_w, sz, br, nb, 1'b1,
                 (is_err(br, sz) || nb != int'(len_w) + 1) ? 2'b10 : 2'b00);
      join
      do_read(4'($urandom), a_wr, len_w, 3'd2, 2'b01, 1, 16'h0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3-style slave memory that answers the burst read/write traffic issued by the core's `axi_bridge` master (I-cache/D-cache line refills, write-backs, uncached accesses). It holds a byte-writable word array and returns responses with id echo, correct `rlast` and `bresp`. It is the simulation and FPGA-side memory endpoint for `mycpu_top`. It supports one outstanding read and one outstanding write, and the two run concurrently.

## Interface
- `MEM_WORDS_LOG2`, default 16: array depth is 2^MEM_WORDS_LOG2 32-bit words. Word index is `addr[MEM_WORDS_LOG2+1:2]`. Upper address bits are ignored, so addresses alias.
- `aclk` in 1: clock; all logic on the rising edge.
- `aresetn` in 1: reset, asynchronous and active-low.
- `arid/araddr/arlen/arsize/arburst` in 4/32/8/3/2: read address fields. `arlock/arcache/arprot` in 2/4/3, ignored.
- `arvalid` in 1 / `arready` out 1: read address handshake.
- `rid/rdata/rresp/rlast` out 4/32/2/1; `rvalid` out 1 / `rready` in 1: read data channel.
- `awid/awaddr/awlen/awsize/awburst` in 4/32/8/3/2: write address fields. `awlock/awcache/awprot` in, ignored.
- `awvalid` in 1 / `awready` out 1: write address handshake.
- `wid` in 4 (ignored), `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1 / `wready` out 1: write data channel.
- `bid/bresp` out 4/2, `bvalid` out 1 / `bready` in 1: write response channel.

## Operation
- Read FSM has two states, R_IDLE and R_BURST.
  - `arready = (state==R_IDLE)`.
  - On `arvalid&&arready`, capture id, address, len, size and burst, clear the beat counter, and go to R_BURST.
  - In R_BURST, `rvalid=1` and `rdata=mem[raddr]` is a combinational array read. `rid` is the captured id. `rlast = (beat==len)`.
  - On `rvalid&&rready`: if `rlast`, go to R_IDLE; else beat+1 and the address advances.
- Address advance is the same rule for reads and writes:
  - FIXED (00): address unchanged.
  - INCR (01): address + (1<<size), 32-bit wrap.
- Error bursts: burst 10 or 11, or size>2.
  - Read: every beat returns `rresp=2'b10` (SLVERR) and `rdata=0`; the beat count is still len+1.
  - Write: no array update.
  - Otherwise `rresp`/`bresp` = 2'b00.
- Write FSM has three states, W_IDLE, W_DATA and W_RESP.
  - `awready = (state==W_IDLE)`. On the AW handshake, capture the fields and go to W_DATA.
  - In W_DATA, `wready=1`. Each `wvalid&&wready` beat writes byte lane i of `mem[waddr]` when `wstrb[i]`, then advances the address.
  - The beat with `wlast=1` goes to W_RESP. If the received beat count ≠ len+1, `bresp`=SLVERR; the writes already performed remain.
  - In W_RESP, `bvalid=1` and `bid` is the captured awid. On `bready`, go to W_IDLE.
- W-before-AW is not accepted, because `wready=0` outside W_DATA.
- Read/write collision on the same word: a write in cycle N is visible to a read beat presented in cycle N+1 or later. Cycle N itself returns the old data.

## Timing
- Reset values: state R_IDLE/W_IDLE, `arready=1`, `awready=1`, `rvalid=0`, `rlast=0`, `rdata=0`, `rid=0`, `rresp=0`, `wready=0`, `bvalid=0`, `bid=0`, `bresp=0`. Array contents are not reset.
- `rdata`, `rlast` and `rresp` are 0 whenever `rvalid=0`.
- Read latency: the AR handshake at edge k gives the first `rvalid` in the cycle after edge k.
  - With `rready` held high, one beat per cycle.
  - A burst of len+1 beats completes at edge k+len+1.
  - The next AR is accepted in the cycle after the last beat.
- Write: the AW handshake at edge k makes `wready` high from the following cycle. The `wlast` beat at edge m gives `bvalid` in the cycle after m.
- Handshake outputs hold stable while the partner is stalled: `rvalid/rdata/rid/rlast` hold under `!rready`, and `bvalid/bid/bresp` hold under `!bready`.
- Reset asserted mid-burst returns both FSMs to idle immediately (asynchronous). The outstanding transactions are dropped, and writes already done stay in the array.

## Test plan
- **Write-then-read line:** AW addr 0x1C000040, len 7, size 2, INCR, id 1; 8 W beats of data 0x100+i, wstrb F, wlast on beat 7 -> `bvalid` with bid=1, bresp=0. Then AR same addr, len 7, id 3 -> 8 beats returning 0x100..0x107, rid=3, `rlast` only on beat 7, 8 consecutive cycles.
- **Byte strobe:** word 0x1C000000 preloaded 0x11223344; single write of 0xAABBCCDD with wstrb 0101 -> read returns 0x11BB33DD.
- **Backpressure:** read len 3 with `rready` toggled 1,0,0,1,1,0,1 -> rvalid/rdata/rlast stable during the low cycles; 4 beats in order; `arready` is 0 until after the last beat.
- **Errors:** AR burst 10, len 1 -> 2 beats with rresp=10, rdata=0. AW INCR len 3 with wlast on beat 1 -> bresp=10, two words written.
- **Concurrency and reset:** read burst and write burst overlapping to different addresses -> both complete correctly. `aresetn` low mid-read on beat 2 -> rvalid=0 immediately, arready=1, and the next AR is serviced normally.
